pc_fetch_unit: RTL and testbench

//   Parametrised program counter and instruction fetch stage. Issues one memory

---
 rtl/pc_fetch_if.sv | 29 ++
 rtl/pc_fetch_unit.sv | 121 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: fetch-unit bus bundling the memory req/ack port, the decode valid/ready port
// and the redirect/call/return controls.
interface pc_fetch_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              jmp;
    logic [ADDR_W-1:0] jmp_addr;
    logic              call;
    logic              ret;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              ras_err;

    modport master (
        input  jmp, jmp_addr, call, ret, mem_ack, mem_rdata, instr_ready,
        output mem_req, mem_addr, instr_valid, instr, instr_pc, ras_err
    );
    modport slave (
        output jmp, jmp_addr, call, ret, mem_ack, mem_rdata, instr_ready,
        input  mem_req, mem_addr, instr_valid, instr, instr_pc, ras_err
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and fetch stage with in-flight jump redirects.
// Optional return-address stack enabled by defining PC_FETCH_RAS_EN.
module pc_fetch_unit #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int RESET_PC  = 0,
    parameter int RAS_DEPTH = 4
) (
    input logic         clk,
    input logic         rst_n,
    pc_fetch_if.master  bus
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, ipc_q, ipc_d, raddr_q, raddr_d, nxt_pc, pc_inc;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              pend_q, pend_d, hs;

    assign hs     = (state_q == HOLD) && bus.instr_ready;
    assign pc_inc = pc_q + ADDR_W'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        pend_d  = pend_q;
        raddr_d = raddr_q;
        if (state_q == IDLE) begin
            state_d = REQ;
            pc_d    = bus.jmp ? bus.jmp_addr : pc_q;
        end else if (state_q == REQ) begin
            if (bus.jmp) begin
                pend_d  = 1'b1;
                raddr_d = bus.jmp_addr;
            end
            // a redirect seen before or with the ack discards the fetched word
            if (bus.mem_ack && (pend_q || bus.jmp)) begin
                state_d = IDLE;
                pc_d    = bus.jmp ? bus.jmp_addr : raddr_q;
                pend_d  = 1'b0;
            end else if (bus.mem_ack) begin
                state_d = HOLD;
                instr_d = bus.mem_rdata;
                ipc_d   = pc_q;
            end
        end else if (state_q != HOLD) begin
            state_d = IDLE;
        end else if (hs) begin
            state_d = REQ;
            pc_d    = nxt_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= ADDR_W'(RESET_PC);
            instr_q <= '0;
            ipc_q   <= '0;
            pend_q  <= 1'b0;
            raddr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            pend_q  <= pend_d;
            raddr_q <= raddr_d;
        end
    end

`ifdef PC_FETCH_RAS_EN
    localparam int IW = RAS_DEPTH > 1 ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [IW-1:0]     top_q, top_inc, top_dec;
    logic [CW-1:0]     cnt_q;
    logic              empty, push, pop, err_q;

    assign empty   = cnt_q == '0;
    assign top_inc = top_q == IW'(RAS_DEPTH - 1) ? '0 : top_q + IW'(1);
    assign top_dec = top_q == '0 ? IW'(RAS_DEPTH - 1) : top_q - IW'(1);
    assign pop     = hs && bus.ret && !empty;
    assign push    = hs && !bus.ret && bus.call;
    assign nxt_pc  = bus.ret ? (empty ? pc_inc : ras_q[top_q]) :
                     (bus.call || bus.jmp) ? bus.jmp_addr : pc_inc;
    assign bus.ras_err = err_q;

    // circular storage: a push when full silently replaces the oldest entry
    always_ff @(posedge clk) begin
        if (push) ras_q[top_inc] <= ipc_q + ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            top_q <= push ? top_inc : pop ? top_dec : top_q;
            cnt_q <= push ? (cnt_q == CW'(RAS_DEPTH) ? cnt_q : cnt_q + CW'(1)) :
                     pop ? cnt_q - CW'(1) : cnt_q;
            err_q <= hs && bus.ret && empty;
        end
    end
`else
    logic [31:0] unused_ras;
    assign unused_ras  = {30'(RAS_DEPTH), bus.call, bus.ret};
    assign nxt_pc      = bus.jmp ? bus.jmp_addr : pc_inc;
    assign bus.ras_err = 1'b0;
`endif

    assign bus.mem_req     = state_q == REQ;
    assign bus.mem_addr    = pc_q;
    assign bus.instr_valid = state_q == HOLD;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = ipc_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenarios plus a randomized run scored against a
// transaction-level model of the expected fetch stream.
module tb_pc_fetch_unit;
    localparam int AW = 8, DW = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0, errors = 0;

    always #5 clk = ~clk;

    pc_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    pc_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(0), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;

    task step;
        @(posedge clk);
        #1;
    endtask

    task idle_inputs;
        bus.jmp = 0; bus.jmp_addr = 0; bus.call = 0; bus.ret = 0;
        bus.mem_ack = 0; bus.mem_rdata = 0; bus.instr_ready = 0;
    endtask

    // leaves the DUT in its first REQ cycle at start (or RESET_PC)
    task do_reset(input logic [AW-1:0] start, input logic use_jmp);
        rst_n = 0; idle_inputs; step; step;
        rst_n = 1; bus.jmp = use_jmp; bus.jmp_addr = start; step;
        bus.jmp = 0;
    endtask

    task test_reset;
        rst_n = 0; idle_inputs; step; step;
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", bus.mem_req); end
        checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL rst_addr got %h exp 00", bus.mem_addr); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.instr_valid); end
        checks++; if (bus.instr !== 8'h00 || bus.instr_pc !== 8'h00) begin errors++; $display("FAIL rst_instr got %h/%h exp 00/00", bus.instr, bus.instr_pc); end
        checks++; if (bus.ras_err !== 1'b0) begin errors++; $display("FAIL rst_ras_err got %b exp 0", bus.ras_err); end
        rst_n = 1; step;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h00) begin errors++; $display("FAIL rst_first_req got %b/%h exp 1/00", bus.mem_req, bus.mem_addr); end
    endtask

    task test_sequential;
        logic [DW-1:0] d;
        do_reset(8'h00, 1'b0);
        bus.instr_ready = 1;
        for (int i = 0; i < 258; i++) begin
            checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'(i)) begin errors++; $display("FAIL seq_addr got %b/%h exp 1/%h", bus.mem_req, bus.mem_addr, 8'(i)); end
            d = 8'($urandom); bus.mem_ack = 1; bus.mem_rdata = d; step; bus.mem_ack = 0;
            checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== d || bus.instr_pc !== 8'(i) || bus.mem_req !== 1'b0) begin
                errors++; $display("FAIL seq_instr got v%b %h@%h req%b exp v1 %h@%h req0", bus.instr_valid, bus.instr, bus.instr_pc, bus.mem_req, d, 8'(i));
            end
            step;
        end
    endtask

    task test_ack_delay;
        logic [DW-1:0] d;
        do_reset(8'h05, 1'b1);
        bus.instr_ready = 1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h05 || bus.instr_valid !== 1'b0) begin
                errors++; $display("FAIL delay_wait got req%b %h v%b exp req1 05 v0", bus.mem_req, bus.mem_addr, bus.instr_valid);
            end
            bus.mem_rdata = 8'($urandom); step;
        end
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h05) begin errors++; $display("FAIL delay_4th got req%b %h exp req1 05", bus.mem_req, bus.mem_addr); end
        d = 8'($urandom); bus.mem_ack = 1; bus.mem_rdata = d; step; bus.mem_ack = 0; bus.mem_rdata = ~d;
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== d || bus.instr_pc !== 8'h05) begin
            errors++; $display("FAIL delay_instr got v%b %h@%h exp v1 %h@05", bus.instr_valid, bus.instr, bus.instr_pc, d);
        end
        step;
        checks++; if (bus.instr_valid !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h06) begin
            errors++; $display("FAIL delay_next got v%b req%b %h exp v0 req1 06", bus.instr_valid, bus.mem_req, bus.mem_addr);
        end
    endtask

    task test_stall;
        logic [DW-1:0] d;
        do_reset(8'h06, 1'b1);
        d = 8'($urandom); bus.mem_ack = 1; bus.mem_rdata = d; step; bus.mem_ack = 0;
        bus.jmp = 1; bus.jmp_addr = 8'h77;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== d || bus.instr_pc !== 8'h06 || bus.mem_req !== 1'b0) begin
                errors++; $display("FAIL stall_hold got v%b %h@%h req%b exp v1 %h@06 req0", bus.instr_valid, bus.instr, bus.instr_pc, bus.mem_req, d);
            end
            bus.mem_rdata = 8'($urandom); step;
        end
        bus.instr_ready = 1; bus.jmp_addr = 8'h40; step; bus.jmp = 0;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h40) begin errors++; $display("FAIL stall_jmp got req%b %h exp req1 40", bus.mem_req, bus.mem_addr); end
    endtask

    task test_redirect;
        logic [DW-1:0] d;
        do_reset(8'h07, 1'b1);
        bus.instr_ready = 1;
        bus.jmp = 1; bus.jmp_addr = 8'h20; step;
        bus.jmp_addr = 8'h30; step; bus.jmp = 0;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h07) begin errors++; $display("FAIL redir_stable got req%b %h exp req1 07", bus.mem_req, bus.mem_addr); end
        bus.mem_ack = 1; bus.mem_rdata = 8'hAA; step; bus.mem_ack = 0;
        checks++; if (bus.mem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.mem_addr !== 8'h30) begin
            errors++; $display("FAIL redir_drop got req%b v%b %h exp req0 v0 30", bus.mem_req, bus.instr_valid, bus.mem_addr);
        end
        step;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h30) begin errors++; $display("FAIL redir_reissue got req%b %h exp req1 30", bus.mem_req, bus.mem_addr); end
        bus.mem_ack = 1; bus.jmp = 1; bus.jmp_addr = 8'h55; step; bus.mem_ack = 0; bus.jmp = 0;
        checks++; if (bus.mem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL redir_same got req%b v%b exp req0 v0", bus.mem_req, bus.instr_valid); end
        step;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h55) begin errors++; $display("FAIL redir_same_addr got req%b %h exp req1 55", bus.mem_req, bus.mem_addr); end
        d = 8'($urandom); bus.mem_ack = 1; bus.mem_rdata = d; step; bus.mem_ack = 0;
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== d || bus.instr_pc !== 8'h55) begin
            errors++; $display("FAIL redir_after got v%b %h@%h exp v1 %h@55", bus.instr_valid, bus.instr, bus.instr_pc, d);
        end
        step;
    endtask

    task test_reset_mid;
        do_reset(8'h12, 1'b1);
        step;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h12) begin errors++; $display("FAIL rmid_pre got req%b %h exp req1 12", bus.mem_req, bus.mem_addr); end
        #2 rst_n = 0; #1;
        checks++; if (bus.mem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.mem_addr !== 8'h00) begin
            errors++; $display("FAIL rmid_async got req%b v%b %h exp req0 v0 00", bus.mem_req, bus.instr_valid, bus.mem_addr);
        end
        step; rst_n = 1; step;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h00) begin errors++; $display("FAIL rmid_resume got req%b %h exp req1 00", bus.mem_req, bus.mem_addr); end
    endtask

`ifdef PC_FETCH_RAS_EN
    task test_ras;
        logic [AW-1:0] cur, exp_pc;
        logic [AW-1:0] ras_m[$];
        logic          exp_err;
        do_reset(8'h03, 1'b1);
        bus.instr_ready = 1;
        bus.mem_ack = 1; step; bus.mem_ack = 0;
        bus.call = 1; bus.jmp_addr = 8'h10; step; bus.call = 0;
        checks++; if (bus.mem_addr !== 8'h10) begin errors++; $display("FAIL ras_call got %h exp 10", bus.mem_addr); end
        bus.mem_ack = 1; step; bus.mem_ack = 0;
        bus.ret = 1; step; bus.ret = 0;
        checks++; if (bus.mem_addr !== 8'h04 || bus.ras_err !== 1'b0) begin errors++; $display("FAIL ras_ret got %h err%b exp 04 err0", bus.mem_addr, bus.ras_err); end
        bus.mem_ack = 1; step; bus.mem_ack = 0;
        bus.ret = 1; step; bus.ret = 0;
        checks++; if (bus.mem_addr !== 8'h05 || bus.ras_err !== 1'b1) begin errors++; $display("FAIL ras_empty got %h err%b exp 05 err1", bus.mem_addr, bus.ras_err); end
        step;
        checks++; if (bus.ras_err !== 1'b0) begin errors++; $display("FAIL ras_pulse got %b exp 0", bus.ras_err); end
        cur = 8'h05;
        for (int k = 0; k < 5; k++) begin
            bus.mem_ack = 1; step; bus.mem_ack = 0;
            ras_m.push_back(cur + 8'd1);
            if (ras_m.size() > 4) void'(ras_m.pop_front());
            cur = 8'(8'h20 + 16 * k);
            bus.call = 1; bus.jmp_addr = cur; step; bus.call = 0;
            checks++; if (bus.mem_addr !== cur) begin errors++; $display("FAIL ras_push got %h exp %h", bus.mem_addr, cur); end
        end
        for (int k = 0; k < 5; k++) begin
            bus.mem_ack = 1; step; bus.mem_ack = 0;
            exp_err = ras_m.size() == 0;
            exp_pc  = exp_err ? cur + 8'd1 : ras_m.pop_back();
            bus.ret = 1; step; bus.ret = 0;
            checks++; if (bus.mem_addr !== exp_pc || bus.ras_err !== exp_err) begin
                errors++; $display("FAIL ras_pop got %h err%b exp %h err%b", bus.mem_addr, bus.ras_err, exp_pc, exp_err);
            end
            cur = exp_pc;
        end
    endtask
`else
    task test_ras;
        do_reset(8'h03, 1'b1);
        bus.instr_ready = 1;
        bus.mem_ack = 1; step; bus.mem_ack = 0;
        bus.call = 1; bus.jmp_addr = 8'h10; step; bus.call = 0;
        checks++; if (bus.mem_addr !== 8'h04 || bus.ras_err !== 1'b0) begin errors++; $display("FAIL noras_call got %h err%b exp 04 err0", bus.mem_addr, bus.ras_err); end
        bus.mem_ack = 1; step; bus.mem_ack = 0;
        bus.ret = 1; step; bus.ret = 0;
        checks++; if (bus.mem_addr !== 8'h05 || bus.ras_err !== 1'b0) begin errors++; $display("FAIL noras_ret got %h err%b exp 05 err0", bus.mem_addr, bus.ras_err); end
        step;
        checks++; if (bus.ras_err !== 1'b0) begin errors++; $display("FAIL noras_err got %b exp 0", bus.ras_err); end
    endtask
`endif

    task test_random;
        logic [AW-1:0] exp_addr, pend_addr, ja;
        logic          pend, j;
        ent_t          q[$];
        int            delivered;
        do_reset(8'h00, 1'b0);
        exp_addr = 8'h00; pend = 0; pend_addr = 0; delivered = 0;
        for (int n = 0; n < 3000; n++) begin
            j  = $urandom_range(0, 7) == 0;
            ja = 8'($urandom);
            bus.jmp = j; bus.jmp_addr = ja;
            bus.instr_ready = $urandom_range(0, 3) != 0;
            bus.mem_rdata = 8'($urandom);
            bus.mem_ack = bus.mem_req && ($urandom_range(0, 1) == 1);
`ifdef PC_FETCH_RAS_EN
            bus.call = 0; bus.ret = 0;
`else
            bus.call = 1'($urandom); bus.ret = 1'($urandom);
`endif
            checks++; if (bus.ras_err !== 1'b0) begin errors++; $display("FAIL rnd_ras_err got %b exp 0", bus.ras_err); end
            if (bus.mem_req === 1'b1) begin
                checks++; if (bus.mem_addr !== exp_addr || bus.instr_valid !== 1'b0) begin
                    errors++; $display("FAIL rnd_addr got %h v%b exp %h v0", bus.mem_addr, bus.instr_valid, exp_addr);
                end
                if (j) begin pend = 1; pend_addr = ja; end
                if (bus.mem_ack && pend) begin exp_addr = pend_addr; pend = 0; end
                else if (bus.mem_ack) q.push_back('{exp_addr, bus.mem_rdata});
            end else if (bus.instr_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL rnd_spurious got valid@%h exp no instr", bus.instr_pc); end
                else if (bus.instr !== q[0].d || bus.instr_pc !== q[0].a) begin
                    errors++; $display("FAIL rnd_instr got %h@%h exp %h@%h", bus.instr, bus.instr_pc, q[0].d, q[0].a);
                end
                if (bus.instr_ready && q.size() != 0) begin
                    exp_addr = j ? ja : 8'(q[0].a + 8'd1);
                    void'(q.pop_front());
                    delivered++;
                end
            end else if (j) begin
                exp_addr = ja;
            end
            step;
        end
        idle_inputs;
        checks++; if (delivered < 100) begin errors++; $display("FAIL rnd_progress got %0d exp >=100", delivered); end
    endtask

    initial begin
        test_reset;
        test_sequential;
        test_ack_delay;
        test_stall;
        test_redirect;
        test_reset_mid;
        test_ras;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
